rv32i_multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32I datapath: PC, register file, ALU, immediate generator, branch comparator and data memory. It replaces the single-cycle control path. Each instruction is split into FETCH/DECODE/EXEC/MEM/WB steps, and the block drives per-step write enables and mux selects. Data-memory accesses use a ready handshake with timeout; the block also keeps a retired-instruction counter and a sticky halt/fault status.

---
 rtl/rv32i_multicycle_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_rv32i_multicycle_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_multicycle_ctrl.sv
// rtl/rv32i_multicycle_ctrl.sv - multi-cycle RV32I control sequencer
module rv32i_multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             br_eq,
  input  logic             br_lt,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             br_un,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd7
  } state_t;

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  // Counter is one value wider than needed so the limit compare never wraps.
  localparam int             ToW     = $clog2(MEM_TIMEOUT + 2);
  localparam logic [ToW-1:0] ToLimit = ToW'(MEM_TIMEOUT);

  state_t         curState, nextState;
  logic [1:0]     nextCause;
  logic [ToW-1:0] toCnt;
  logic           legalOp, isLoad, taken, retire;
  logic           irWr, pcWr, memRd, memWr, regWr;

  assign isLoad = (opcode == OpLoad);

  always_comb begin
    case (opcode)
      OpReg, OpImm, OpLoad, OpStore, OpBranch,
      OpJal, OpJalr, OpLui, OpAuipc: legalOp = 1'b1;
      default:                       legalOp = 1'b0;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:         taken = br_eq;
      3'b001:         taken = ~br_eq;
      3'b100, 3'b110: taken = br_lt;
      3'b101, 3'b111: taken = ~br_lt;
      default:        taken = 1'b0;
    endcase
  end

  always_comb begin
    nextState = curState;
    nextCause = 2'b00;
    irWr      = 1'b0;
    pcWr      = 1'b0;
    memRd     = 1'b0;
    memWr     = 1'b0;
    regWr     = 1'b0;
    retire    = 1'b0;
    pc_src    = 1'b0;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_op    = 2'b00;
    br_un     = 1'b0;
    wb_sel    = 2'b00;
    case (curState)
      FETCH: begin
        irWr      = 1'b1;
        nextState = DECODE;
      end
      DECODE: begin
        if (!legalOp || (opcode == OpBranch && funct3[2:1] == 2'b01)) begin
          nextState = HALT;
          nextCause = 2'b01;
        end else begin
          nextState = EXEC;
        end
      end
      EXEC: begin
        case (opcode)
          OpReg: begin
            alu_op    = 2'b10;
            nextState = WB;
          end
          OpImm: begin
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
            nextState = WB;
          end
          OpLui: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            nextState = WB;
          end
          OpAuipc: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            nextState = WB;
          end
          OpLoad, OpStore: begin
            alu_src_b = 2'b01;
            nextState = MEM;
          end
          OpBranch: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            br_un     = funct3[1];
            pcWr      = 1'b1;
            pc_src    = taken;
            retire    = 1'b1;
            nextState = FETCH;
          end
          OpJal, OpJalr: begin
            alu_src_a = (opcode == OpJal) ? 2'b01 : 2'b00;
            alu_src_b = 2'b01;
            regWr     = 1'b1;
            wb_sel    = 2'b10;
            pcWr      = 1'b1;
            pc_src    = 1'b1;
            retire    = 1'b1;
            nextState = FETCH;
          end
          default: begin
            nextState = HALT;
            nextCause = 2'b01;
          end
        endcase
      end
      MEM: begin
        alu_src_b = 2'b01;
        memRd     = isLoad;
        memWr     = ~isLoad;
        if (mem_ready) begin
          if (isLoad) begin
            nextState = WB;
          end else begin
            pcWr      = 1'b1;
            retire    = 1'b1;
            nextState = FETCH;
          end
        end else if (MEM_TIMEOUT != 0 && (toCnt + ToW'(1)) == ToLimit) begin
          nextState = HALT;
          nextCause = 2'b10;
        end
      end
      WB: begin
        regWr     = 1'b1;
        wb_sel    = isLoad ? 2'b01 : 2'b00;
        pcWr      = 1'b1;
        retire    = 1'b1;
        nextState = FETCH;
      end
      HALT: nextState = HALT;
      default: begin
        nextState = HALT;
        nextCause = 2'b01;
      end
    endcase
  end

  // Strobes are masked during reset so an abandoned instruction commits nothing.
  assign ir_write  = irWr  & ~reset;
  assign pc_write  = pcWr  & ~reset;
  assign mem_read  = memRd & ~reset;
  assign mem_write = memWr & ~reset;
  assign reg_write = regWr & ~reset;
  assign state     = curState;

  always_ff @(posedge clk) begin
    if (reset) begin
      curState   <= FETCH;
      retired    <= '0;
      halted     <= 1'b0;
      halt_cause <= 2'b00;
      toCnt      <= '0;
    end else begin
      curState <= nextState;
      if (retire) retired <= retired + CNT_W'(1);
      halted <= (nextState == HALT);
      if (nextState == HALT && curState != HALT) halt_cause <= nextCause;
      toCnt <= (curState == MEM && nextState == MEM) ? toCnt + ToW'(1) : '0;
    end
  end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// tb/tb_rv32i_multicycle_ctrl.sv - directed scoreboard bench for rv32i_multicycle_ctrl
module tb_rv32i_multicycle_ctrl;

  localparam int CW = 3;

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          br_eq, br_lt, mem_ready;
  logic          ir_write, pc_write, pc_src, br_un, mem_read, mem_write, reg_write;
  logic [1:0]    alu_src_a, alu_src_b, alu_op, wb_sel, halt_cause;
  logic [2:0]    state;
  logic          halted;
  logic [CW-1:0] retired;

  rv32i_multicycle_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .br_eq(br_eq), .br_lt(br_lt), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .br_un(br_un), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .wb_sel(wb_sel), .state(state),
    .halted(halted), .halt_cause(halt_cause), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    st;
    logic [14:0]   ctl;
    logic          hlt;
    logic [1:0]    cause;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t          expQ[$];
  int            total = 0;
  int            bad   = 0;
  logic [CW-1:0] expRet = '0;
  logic [1:0]    expCause = 2'b00;
  string         step = "init";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", step, tag, obs, want);
    end
  endtask

  // ctl packs {ir, pcw, pcs, a, b, op, bru, mr, mw, rw, wb}
  function automatic exp_t e(input int st, input int ir, input int pcw, input int pcs,
                             input int a, input int b, input int op, input int bru,
                             input int mr, input int mw, input int rw, input int wb);
    exp_t x;
    x.st    = 3'(st);
    x.ctl   = {1'(ir), 1'(pcw), 1'(pcs), 2'(a), 2'(b), 2'(op), 1'(bru),
               1'(mr), 1'(mw), 1'(rw), 2'(wb)};
    x.hlt   = (st == 7);
    x.cause = expCause;
    x.ret   = expRet;
    return x;
  endfunction

  task automatic cyc(input exp_t x, input bit ret);
    exp_t want;
    expQ.push_back(x);
    @(negedge clk);
    want = expQ.pop_front();
    chk("state", 32'(state), 32'(want.st));
    chk("ctl", 32'({ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op, br_un,
                    mem_read, mem_write, reg_write, wb_sel}), 32'(want.ctl));
    chk("halt", 32'({halted, halt_cause}), 32'({want.hlt, want.cause}));
    chk("retired", 32'(retired), 32'(want.ret));
    @(posedge clk);
    #1;
    if (ret) expRet = expRet + 1'b1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge clk);
    chk("rst.strobes", 32'({ir_write, pc_write, mem_read, mem_write, reg_write}), 32'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    expRet   = '0;
    expCause = 2'b00;
  endtask

  task automatic fd();
    cyc(e(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    cyc(e(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
  endtask

  task automatic branch(input logic [2:0] f3, input logic eq, input logic lt,
                        input int tk, input int un);
    step = $sformatf("br%0d_%0d%0d", f3, eq, lt);
    opcode = OpBranch; funct3 = f3; br_eq = eq; br_lt = lt; mem_ready = 1'b1;
    fd();
    cyc(e(2, 0, 1, tk, 1, 1, 0, un, 0, 0, 0, 0), 1);
  endtask

  task automatic addInstr();
    step = "add";
    opcode = OpReg; funct3 = 3'b000; mem_ready = 1'b0;
    fd();
    cyc(e(2, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0), 0);
    cyc(e(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1);
  endtask

  initial begin
    opcode = 7'd0; funct3 = 3'd0; br_eq = 1'b0; br_lt = 1'b0; mem_ready = 1'b0;
    step = "reset";
    doReset();

    addInstr();

    step = "lw";
    opcode = OpLoad; funct3 = 3'b010; mem_ready = 1'b0;
    fd();
    cyc(e(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 0);
    repeat (3) cyc(e(3, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0), 0);
    mem_ready = 1'b1;
    cyc(e(3, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0), 0);
    mem_ready = 1'b0;
    cyc(e(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1), 1);

    branch(3'b110, 1'b0, 1'b1, 1, 1);
    branch(3'b110, 1'b0, 1'b0, 0, 1);
    branch(3'b101, 1'b0, 1'b1, 0, 0);
    branch(3'b001, 1'b0, 1'b0, 1, 0);
    branch(3'b000, 1'b1, 1'b0, 1, 0);

    step = "jalr";
    opcode = OpJalr; funct3 = 3'b000; mem_ready = 1'b0;
    fd();
    cyc(e(2, 0, 1, 1, 0, 1, 0, 0, 0, 0, 1, 2), 1);

    step = "jal";
    opcode = OpJal;
    fd();
    cyc(e(2, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 2), 1);

    step = "lui";
    opcode = OpLui;
    fd();
    cyc(e(2, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0), 0);
    cyc(e(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1);

    step = "auipc";
    opcode = OpAuipc;
    fd();
    cyc(e(2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), 0);
    cyc(e(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1);

    step = "sw0";
    opcode = OpStore; funct3 = 3'b010; mem_ready = 1'b1;
    fd();
    cyc(e(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 0);
    cyc(e(3, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0), 1);

    step = "swrst";
    mem_ready = 1'b0;
    fd();
    cyc(e(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 0);
    cyc(e(3, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0), 0);
    doReset();
    addInstr();

    step = "illegal";
    opcode = 7'b0000000;
    fd();
    expCause = 2'b01;
    repeat (2) cyc(e(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    doReset();

    step = "br010";
    opcode = OpBranch; funct3 = 3'b010;
    fd();
    expCause = 2'b01;
    cyc(e(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    doReset();

    addInstr();
    step = "swto";
    opcode = OpStore; funct3 = 3'b010; mem_ready = 1'b0;
    fd();
    cyc(e(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 0);
    repeat (16) cyc(e(3, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0), 0);
    expCause = 2'b10;
    mem_ready = 1'b1;
    repeat (2) cyc(e(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    doReset();
    step = "postrst";
    mem_ready = 1'b0;
    fd();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
